// File: rtl/axi_burst_frame_reader_pkg.sv
// Shared types and constants for the AXI burst frame reader.
// Build option: AXI_RD_BYTE_FLIP_EN (see top module).
package axi_rd_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} rd_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] AR_CACHE   = 4'b0011;
    localparam logic [2:0] AR_PROT    = 3'b000;
    localparam logic [3:0] AR_QOS     = 4'b0000;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int burst_bytes(input int blen, input int dw);
        return blen * dw / 8;
    endfunction
endpackage

// File: rtl/axi_burst_frame_reader_if.sv
// AXI4 read channels plus the outgoing AXI-Stream, bundled for the frame reader.
interface axi_burst_frame_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic [3:0]            m_axi_arqos;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic                  m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] M_RD_tdata;
    logic                  M_RD_tvalid;
    logic                  M_RD_tready;
    logic                  M_RD_tlast;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output M_RD_tdata, M_RD_tvalid, M_RD_tlast,
        input  M_RD_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  M_RD_tdata, M_RD_tvalid, M_RD_tlast,
        output M_RD_tready
    );
endinterface

// File: rtl/axi_burst_frame_reader_skid.sv
// Two-entry registered skid buffer: an output register plus one overflow slot.
module axi_rd_skid #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;

    // Ready comes straight from a flop, so upstream never sees a combinational path.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/axi_burst_frame_reader.sv
// Frame reader: back-to-back INCR bursts over a ring of frames, re-emitted as a stream.
// Define AXI_RD_BYTE_FLIP_EN to byte-reverse the stream data.
module axi_burst_frame_reader
    import axi_rd_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    BURST_LEN       = 16,
    parameter int                    FRAME_BURSTS    = 64,
    parameter int                    NUM_FRAMES      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    TLAST_PER_FRAME = 1
) (
    input  logic M_RD_aclk,
    input  logic M_RD_areset,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    output logic o_err,
    axi_burst_frame_reader_if.master bus
);
    localparam int BC_W = clog2(FRAME_BURSTS) + 1;
    localparam int FI_W = clog2(NUM_FRAMES) + 1;
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(burst_bytes(BURST_LEN, DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] FRAME_STEP =
        ADDR_WIDTH'(FRAME_BURSTS * burst_bytes(BURST_LEN, DATA_WIDTH));

    rd_state_e             state;
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr, frame_ptr;
    logic [FI_W-1:0]       frame_idx;
    logic [BC_W-1:0]       burst_cnt;
    logic                  skid_ready, rready, r_fire, last_burst, beat_last;
    logic                  out_valid;
    logic [DATA_WIDTH:0]   out_data;
    logic [DATA_WIDTH-1:0] beat_data, flip_data;
    logic                  unused_rid;

    assign unused_rid = bus.m_axi_rid;
    assign rready     = (state == DATA) && skid_ready;
    assign r_fire     = bus.m_axi_rvalid && rready;
    assign last_burst = (burst_cnt == BC_W'(FRAME_BURSTS - 1));
    assign beat_last  = (TLAST_PER_FRAME != 0) ? (bus.m_axi_rlast && last_burst) : bus.m_axi_rlast;

    assign bus.m_axi_arid    = 1'b0;
    assign bus.m_axi_araddr  = araddr;
    assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
    assign bus.m_axi_arsize  = 3'(clog2(DATA_WIDTH / 8));
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = AR_CACHE;
    assign bus.m_axi_arprot  = AR_PROT;
    assign bus.m_axi_arqos   = AR_QOS;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;

    axi_rd_skid #(.W(DATA_WIDTH + 1)) u_skid (
        .clk       (M_RD_aclk),
        .rst       (M_RD_areset),
        .in_valid  (r_fire),
        .in_ready  (skid_ready),
        .in_data   ({beat_last, bus.m_axi_rdata}),
        .out_valid (out_valid),
        .out_ready (bus.M_RD_tready),
        .out_data  (out_data)
    );

    assign beat_data = out_data[DATA_WIDTH-1:0];

    always_comb begin
        flip_data = beat_data;
`ifdef AXI_RD_BYTE_FLIP_EN
        for (int b = 0; b < DATA_WIDTH / 8; b++)
            flip_data[8*b +: 8] = beat_data[DATA_WIDTH-8-8*b +: 8];
`endif
    end

    assign bus.M_RD_tdata  = flip_data;
    assign bus.M_RD_tvalid = out_valid;
    assign bus.M_RD_tlast  = out_data[DATA_WIDTH];

    always_ff @(posedge M_RD_aclk or posedge M_RD_areset) begin
        if (M_RD_areset) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            araddr    <= BASE_ADDR;
            frame_ptr <= BASE_ADDR;
            frame_idx <= '0;
            burst_cnt <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (r_fire && bus.m_axi_rresp != RESP_OKAY) o_err <= 1'b1;
            case (state)
                IDLE: if (i_start) begin
                    o_err     <= 1'b0;
                    o_busy    <= 1'b1;
                    arvalid   <= 1'b1;
                    araddr    <= frame_ptr;
                    burst_cnt <= '0;
                    state     <= ADDR;
                end
                ADDR: if (bus.m_axi_arready) begin
                    arvalid <= 1'b0;
                    state   <= DATA;
                end
                DATA: if (r_fire && bus.m_axi_rlast) begin
                    if (last_burst) begin
                        state <= DRAIN;
                    end else begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                        araddr    <= araddr + BURST_STEP;
                        arvalid   <= 1'b1;
                        state     <= ADDR;
                    end
                end
                // No new beats arrive here, so an empty skid slot means the output reg holds the final beat.
                DRAIN: if (skid_ready && out_valid && bus.M_RD_tready) begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                    if (frame_idx == FI_W'(NUM_FRAMES - 1)) begin
                        frame_idx <= '0;
                        frame_ptr <= BASE_ADDR;
                    end else begin
                        frame_idx <= frame_idx + FI_W'(1);
                        frame_ptr <= frame_ptr + FRAME_STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
